// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence engine: FSM encoding, default sizes
// and the constants substituted for an all-zero seed or tap mask.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LFSR_WIDTH_DEF = 8;
    localparam int LFSR_CNT_W_DEF = 8;

    // An all-zero seed would lock the register at zero forever.
    localparam logic [31:0] SEED_GUARD = 32'd1;

    // An empty tap mask becomes MSB-only feedback, i.e. a plain rotate.
    function automatic logic [31:0] taps_guard(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: shift toward the MSB, parity of the tapped bits
// enters the LSB. Purely combinational so a multi-channel bank can reuse it.
module lfsr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] taps_i,
    output logic [WIDTH-1:0] nxt_o
);

    assign nxt_o = {num_i[WIDTH-2:0], ^(num_i & taps_i)};

endmodule

// File: rtl/lfsr_seq_gen.sv
// Parametrised LFSR sequence engine: load seed/taps, advance seq_num steps,
// present the result under valid/ready. Optional macro: LFSR_STREAM_EN.
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH_DEF,
    parameter int CNT_W = LFSR_CNT_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    input  logic [CNT_W-1:0] seq_num,
    output logic             busy,
    output logic [WIDTH-1:0] num,
    output logic             result_valid,
    input  logic             result_ready
`ifdef LFSR_STREAM_EN
    ,
    output logic             stream_valid,
    input  logic             stream_ready
`endif
);

    localparam logic [WIDTH-1:0] SEED_G = WIDTH'(SEED_GUARD);
    localparam logic [WIDTH-1:0] TAPS_G = WIDTH'(taps_guard(WIDTH));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] nxt;
    logic             step_ok;

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .num_i  (num_q),
        .taps_i (taps_q),
        .nxt_o  (nxt)
    );

`ifdef LFSR_STREAM_EN
    // Each beat shows the pre-step value; the step happens on the accepting edge.
    assign stream_valid = (state_q == ST_RUN) && (cnt_q != '0);
    assign step_ok      = stream_ready;
`else
    assign step_ok      = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        taps_d  = taps_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = (seed == '0) ? SEED_G : seed;
                    taps_d  = (taps == '0) ? TAPS_G : taps;
                    cnt_d   = seq_num;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if (step_ok) begin
                    num_d = nxt;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; it is never queued.
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            taps_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            taps_q  <= taps_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded straight from the state register so nothing pulses during reset.
    assign busy         = (state_q == ST_RUN);
    assign result_valid = (state_q == ST_DONE);
    assign num          = num_q;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Directed bench for lfsr_seq_gen (WIDTH=8, CNT_W=8); stream case only when
// LFSR_STREAM_EN is defined.
module tb_lfsr_seq_gen;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = '0;
    logic [7:0] taps = '0;
    logic [7:0] seq_num = '0;
    logic       busy;
    logic [7:0] num;
    logic       result_valid;
    logic       result_ready = 1'b0;
`ifdef LFSR_STREAM_EN
    logic       stream_valid;
    logic       stream_ready = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    lfsr_seq_gen #(.WIDTH(8), .CNT_W(8)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .start        (start),
        .seed         (seed),
        .taps         (taps),
        .seq_num      (seq_num),
        .busy         (busy),
        .num          (num),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef LFSR_STREAM_EN
        ,
        .stream_valid (stream_valid),
        .stream_ready (stream_ready)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present start with operands at a negedge; it is taken on the next posedge.
    task automatic kick(input logic [7:0] s, input logic [7:0] t, input logic [7:0] n);
        start = 1'b1; seed = s; taps = t; seq_num = n;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        logic zero_seen;
        logic [7:0] hold;

        // Reset state
        @(negedge wb_clk_i);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_num", num, 8'h00);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);

        // 1: seed 01, taps 03, 3 steps -> 01,03,06,0D
        kick(8'h01, 8'h03, 8'd3);
        seed = 8'hFF; taps = 8'hFF; seq_num = 8'd9;  // must not disturb the run
        chk("t1_load", num, 8'h01);
        chk("t1_busy", busy, 1);
        @(negedge wb_clk_i); chk("t1_s1", num, 8'h03);
        @(negedge wb_clk_i); chk("t1_s2", num, 8'h06);
        @(negedge wb_clk_i); chk("t1_s3", num, 8'h0D);
        chk("t1_nvalid", result_valid, 0);
        @(negedge wb_clk_i);
        chk("t1_valid", result_valid, 1);
        chk("t1_final", num, 8'h0D);
        chk("t1_idlebusy", busy, 0);
        result_ready = 1'b1;
        @(negedge wb_clk_i);
        chk("t1_drop", result_valid, 0);

        // 2: seq_num 0 returns seed; result_ready already high -> 1-cycle DONE
        kick(8'h5A, 8'h77, 8'd0);
        chk("t2_load", num, 8'h5A);
        chk("t2_nvalid", result_valid, 0);
        @(negedge wb_clk_i);
        chk("t2_valid", result_valid, 1);
        chk("t2_num", num, 8'h5A);
        @(negedge wb_clk_i);
        chk("t2_drop", result_valid, 0);
        result_ready = 1'b0;

        // 3: zero seed guarded to 01, taps B8, 255 steps -> full period back to 01
        kick(8'h00, 8'hB8, 8'd255);
        chk("t3_guard", num, 8'h01);
        zero_seen = 1'b0;
        cyc = 0;
        while (!result_valid && cyc < 400) begin
            @(negedge wb_clk_i);
            cyc++;
            if (num == 8'h00) zero_seen = 1'b1;
        end
        chk("t3_latency", cyc, 256);
        chk("t3_final", num, 8'h01);
        chk("t3_nozero", zero_seen, 0);

        // 4: DONE held 10 cycles with a start pulse in the middle
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            seed  = 8'h33;
            @(negedge wb_clk_i);
            chk("t4_hold_valid", result_valid, 1);
            chk("t4_hold_num", num, 8'h01);
        end
        // start and result_ready together: return to IDLE, start not queued
        start = 1'b1; result_ready = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0; result_ready = 1'b0;
        chk("t4_release", result_valid, 0);
        chk("t4_nobusy", busy, 0);
        @(negedge wb_clk_i);
        chk("t4_notqueued", busy, 0);
        chk("t4_num_kept", num, 8'h01);

        // 5: reset mid-run with count=5
        kick(8'h01, 8'h03, 8'd8);
        repeat (3) @(negedge wb_clk_i);
        chk("t5_prerst", busy, 1);
        wb_rst_i = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_num", num, 8'h00);
        chk("t5_valid", result_valid, 0);
        @(negedge wb_clk_i);
        chk("t5_held", busy, 0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        // zero taps become a rotate: 81 -> 03 -> 06
        kick(8'h81, 8'h00, 8'd2);
        chk("t5_load", num, 8'h81);
        @(negedge wb_clk_i); chk("t5_rot1", num, 8'h03);
        @(negedge wb_clk_i); chk("t5_rot2", num, 8'h06);
        @(negedge wb_clk_i);
        chk("t5_valid2", result_valid, 1);
        chk("t5_final", num, 8'h06);
        result_ready = 1'b1;
        @(negedge wb_clk_i);
        result_ready = 1'b0;
        chk("t5_drop", result_valid, 0);

`ifdef LFSR_STREAM_EN
        // 6: stream with stream_ready 1,0,1,0,1,0
        begin
            logic [7:0] beats [$];
            logic [5:0] pat;
            pat = 6'b010101;  // bit i is the ready level for edge i
            kick(8'h01, 8'h03, 8'd3);
            cyc = 0;
            while (!result_valid && cyc < 20) begin
                stream_ready = (cyc < 6) ? pat[cyc] : 1'b1;
                hold = num;
                if (stream_valid && stream_ready) beats.push_back(num);
                @(negedge wb_clk_i);
                if (cyc < 6 && !pat[cyc]) chk("t6_stall_hold", num, hold);
                cyc++;
            end
            stream_ready = 1'b0;
            chk("t6_nbeats", beats.size(), 3);
            if (beats.size() == 3) begin
                chk("t6_beat0", beats[0], 8'h01);
                chk("t6_beat1", beats[1], 8'h03);
                chk("t6_beat2", beats[2], 8'h06);
            end
            chk("t6_valid", result_valid, 1);
            chk("t6_final", num, 8'h0D);
            chk("t6_sv_low", stream_valid, 0);
            result_ready = 1'b1;
            @(negedge wb_clk_i);
            result_ready = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
